// File: rtl/mam_dii_req_unpack.sv
`timescale 1ns/1ps
// mam_dii_req_unpack
// Turns MAM read/write packets arriving as 16-bit DII flits into one memory
// request plus DATA_WIDTH-wide write beats. Burst writes may continue over
// several packets. Malformed packets raise a one-cycle err_pkt pulse and the
// rest of the packet is dropped.
//
// Handshakes: every interface uses valid/ready. A transfer happens on a rising
// clock edge where both are high. The producer holds valid and its payload
// stable until that edge, and never withdraws valid once raised. Ready may
// depend combinationally on state but never on the matching valid.
module mam_dii_req_unpack #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             debug_in_data,
    input  logic                    debug_in_valid,
    input  logic                    debug_in_last,
    output logic                    debug_in_ready,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_rw,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    req_burst,
    output logic [13:0]             req_beats,
    output logic                    write_valid,
    input  logic                    write_ready,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    err_pkt,
    output logic                    busy,
    output logic [3:0]              state_dbg
);

    localparam int WF = DATA_WIDTH / 16;
    localparam int AF = ADDR_WIDTH / 16;
    localparam logic [3:0] WF_LAST = 4'(WF - 1);
    localparam logic [3:0] AF_LAST = 4'(AF - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR1, S_MHDR, S_ADDR, S_REQ, S_DATA, S_CONT0, S_CONT1, S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rw_q, rw_d;
    logic                    burst_q, burst_d;
    logic [13:0]             beats_q, beats_d;
    logic [13:0]             beat_cnt_q, beat_cnt_d;
    logic                    pkt_end_q, pkt_end_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [3:0]              flit_cnt_q, flit_cnt_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wvalid_q, wvalid_d;
    logic                    rvalid_q, rvalid_d;
    logic                    err_q, err_d;

    logic                    fire;
    logic [ADDR_WIDTH-1:0]   addr_shift;
    logic [DATA_WIDTH-1:0]   asm_shift;
    logic [13:0]             beats_left;
    logic [13:0]             hdr_beats;

    // Flit acceptance depends only on state (and the write output slot in DATA).
    always_comb begin
        case (state_q)
            S_REQ:   debug_in_ready = 1'b0;
            S_DATA:  debug_in_ready = !wvalid_q || write_ready;
            default: debug_in_ready = 1'b1;
        endcase
    end

    // Datapath helpers: shift-in registers, saturating beat decrement, header beats.
    always_comb begin
        fire       = debug_in_valid && debug_in_ready;
        addr_shift = (addr_q << 16) | ADDR_WIDTH'(debug_in_data);
        asm_shift  = (asm_q << 16) | DATA_WIDTH'(debug_in_data);
        beats_left = (beat_cnt_q != 14'd0) ? beat_cnt_q - 14'd1 : 14'd0;
        hdr_beats  = debug_in_data[14] ? debug_in_data[13:0] : 14'd1;
    end

    // Packet parser: next state and next register values.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        burst_d    = burst_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        pkt_end_d  = pkt_end_q;
        asm_d      = asm_q;
        flit_cnt_d = flit_cnt_q;
        wdata_d    = wdata_q;
        wvalid_d   = wvalid_q;
        rvalid_d   = rvalid_q;
        err_d      = 1'b0;
        if (wvalid_q && write_ready) wvalid_d = 1'b0;
        case (state_q)
            S_IDLE: if (fire) begin
                if (debug_in_last) err_d = 1'b1;
                else state_d = S_HDR1;
            end
            S_HDR1: if (fire) begin
                if (debug_in_last) begin err_d = 1'b1; state_d = S_IDLE; end
                else state_d = S_MHDR;
            end
            S_MHDR: if (fire) begin
                rw_d       = debug_in_data[15];
                burst_d    = debug_in_data[14];
                beats_d    = hdr_beats;
                beat_cnt_d = hdr_beats;
                flit_cnt_d = 4'd0;
                if (debug_in_last) begin err_d = 1'b1; state_d = S_IDLE; end
                else if (hdr_beats == 14'd0) begin err_d = 1'b1; state_d = S_DRAIN; end
                else state_d = S_ADDR;
            end
            S_ADDR: if (fire) begin
                addr_d = addr_shift;
                if (flit_cnt_q == AF_LAST) begin
                    // Remember whether the header packet ended on the address.
                    pkt_end_d = debug_in_last;
                    rvalid_d  = 1'b1;
                    state_d   = S_REQ;
                end else if (debug_in_last) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    flit_cnt_d = flit_cnt_q + 4'd1;
                end
            end
            S_REQ: if (req_ready) begin
                rvalid_d   = 1'b0;
                flit_cnt_d = 4'd0;
                if (!rw_q) begin
                    // Reads carry no data; anything after the address is junk.
                    if (pkt_end_q) state_d = S_IDLE;
                    else begin err_d = 1'b1; state_d = S_DRAIN; end
                end else if (pkt_end_q) begin
                    state_d = S_CONT0;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: if (fire) begin
                asm_d = asm_shift;
                if (flit_cnt_q == WF_LAST) begin
                    flit_cnt_d = 4'd0;
                    wdata_d    = asm_shift;
                    wvalid_d   = 1'b1;
                    beat_cnt_d = beats_left;
                    if (beats_left == 14'd0) begin
                        if (debug_in_last) state_d = S_IDLE;
                        else begin err_d = 1'b1; state_d = S_DRAIN; end
                    end else if (debug_in_last) begin
                        state_d = S_CONT0;
                    end
                end else begin
                    flit_cnt_d = flit_cnt_q + 4'd1;
                    if (debug_in_last) begin err_d = 1'b1; state_d = S_IDLE; end
                end
            end
            S_CONT0: if (fire) begin
                if (debug_in_last) begin err_d = 1'b1; state_d = S_IDLE; end
                else state_d = S_CONT1;
            end
            S_CONT1: if (fire) begin
                if (debug_in_last) begin err_d = 1'b1; state_d = S_IDLE; end
                else begin flit_cnt_d = 4'd0; state_d = S_DATA; end
            end
            S_DRAIN: if (fire && debug_in_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any partial packet and pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            burst_q    <= 1'b0;
            beats_q    <= 14'd0;
            beat_cnt_q <= 14'd0;
            pkt_end_q  <= 1'b0;
            asm_q      <= '0;
            flit_cnt_q <= 4'd0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            burst_q    <= burst_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_end_q  <= pkt_end_d;
            asm_q      <= asm_d;
            flit_cnt_q <= flit_cnt_d;
            wdata_q    <= wdata_d;
            wvalid_q   <= wvalid_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign req_valid   = rvalid_q;
    assign req_rw      = rw_q;
    assign req_addr    = addr_q;
    assign req_burst   = burst_q;
    assign req_beats   = beats_q;
    assign write_valid = wvalid_q;
    assign write_data  = wdata_q;
    assign write_strb  = '1;
    assign err_pkt     = err_q;
    assign busy        = (state_q != S_IDLE) || wvalid_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/mam_dii_req_unpack.md
# mam_dii_req_unpack

Parametrised DII-to-memory request unpacker for the MAM datapath. It consumes 16-bit DII flits carrying MAM read and write packets, including burst writes split across several packets. It emits one memory request plus DATA_WIDTH-wide write beats, assembled from DATA_WIDTH/16 flits each, and flags malformed packets. It sits between the debug ring input of the MAM and the memory-side request/write interface.

## Interface
- DATA_WIDTH, 16: memory word width; multiple of 16, 16..128; WF = DATA_WIDTH/16 flits per word.
- ADDR_WIDTH, 32: address width; multiple of 16, 16..64; AF = ADDR_WIDTH/16 address flits.
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- debug_in  in  dii_flit  input flit (data[15:0], valid, last).
- debug_in_ready  out  1  flit accepted when valid && ready.
- req_valid / req_ready  out / in  1 / 1  request handshake.
- req_rw  out  1  1 = write.
- req_addr  out  ADDR_WIDTH  start address.
- req_burst  out  1  burst flag.
- req_beats  out  14  beat count.
- write_valid / write_ready  out / in  1 / 1  write beat handshake.
- write_data  out  DATA_WIDTH  beat data.
- write_strb  out  DATA_WIDTH/8  always all ones.
- err_pkt  out  1  one-cycle pulse per malformed packet.
- busy  out  1  high whenever state != IDLE or write_valid.

## Operation
- Packet layout:
  - flit0 = destination.
  - flit1 = source/type.
  - flit2 = MAM header: [15] rw, [14] burst, [13:0] beats. burst=0 forces beats=1.
  - then AF address flits, MSB first.
  - then, for writes, data words of WF flits each, MSB flit first.
- Continuation packets carry flit0 and flit1, then data only. A word never straddles packets.
- States and transitions:
  - IDLE: accept dest flit -> HDR1.
  - HDR1: accept -> MHDR.
  - MHDR: latch rw, burst, beats -> ADDR.
  - ADDR: shift AF flits into the address register. After the final one -> REQ.
  - REQ: debug_in_ready=0, req_valid=1. Exit on req_ready:
    - read -> IDLE if the address flit carried last, else DRAIN with err_pkt.
    - write whose packet already ended -> CONT0.
    - write otherwise -> DATA.
  - DATA: shift flits into the assembly register. On the WF-th flit, move the word to the output register, set write_valid and decrement the beat counter.
    - counter reaches 0 with last -> IDLE.
    - counter reaches 0 without last -> error.
    - word completes with last and beats remaining -> CONT0.
    - last mid-word -> error.
  - CONT0 -> CONT1 -> DATA: header flits discarded.
- Errors:
  - last on flit0, flit1, MHDR or a non-final address flit.
  - burst=1 with beats=0.
  - any of the DATA / REQ error cases above.
  - On error: err_pkt pulses for one cycle. If the offending flit had last -> IDLE, else DRAIN.
  - DRAIN accepts and discards flits through last, then goes to IDLE.
  - Beats already issued stay issued. The memory side sees a short burst, and no further write_valid is raised for that request.
- debug_in_ready is combinational from state:
  - 1 in IDLE, HDR1, MHDR, ADDR, CONT0, CONT1, DRAIN.
  - in DATA: !write_valid || write_ready.
  - 0 in REQ.
- Arithmetic:
  - beat counter is 14 bits and never wraps; decrement is gated at 0.
  - address register shifts left by 16 per flit.

## Timing
- Reset values:
  - req_valid, write_valid, err_pkt, busy = 0.
  - req_* fields, write_data = 0.
  - write_strb = all ones.
  - debug_in_ready = 1 (state IDLE).
- Throughput: one flit per cycle when unstalled.
- req_valid rises the cycle after the final address flit is accepted. It holds with stable fields until req_ready.
- write_valid rises the cycle after the WF-th flit of a word is accepted. It holds with stable data until write_ready.
- A new word may load in the same cycle the previous one is consumed (write_valid && write_ready).
- err_pkt is registered: it pulses the cycle after the offending flit is accepted.
- Reset mid-packet: all state returns to IDLE immediately, and the partial packet and any pending word are discarded.
- After reset, the next flit is treated as flit0 of a new packet.

## Test plan
- DATA_WIDTH=16, write_ready=0 for 500 ns.
  - Stimulus: single write 0000,4000,8000,0000,0000,000F.
  - Required: req (rw=1, burst=0, beats=1, addr=0); write_data=000F held until write_ready; a second single write, 000C, follows.
- DATA_WIDTH=16, burst split over two packets.
  - Stimulus: 0000,4000,C006,0000,0000,0001,0002,0003|last, then 0000,4000,0004,0005,0006|last.
  - Required: six beats 0001..0006, then IDLE; err_pkt never pulses.
- DATA_WIDTH=32, ADDR_WIDTH=32.
  - Stimulus: 0000,4000,C002,1234,5678,AAAA,BBBB,CCCC,DDDD|last.
  - Required: req_addr=12345678, beats=2; write_data AAAABBBB then CCCCDDDD.
- Address-only first packet.
  - Stimulus: header + address with last, then two continuation packets.
  - Required: req issued once; all beats in order.
- Malformed packets.
  - Stimulus: last mid-word in a 32-bit burst.
  - Required: err_pkt single pulse, return to IDLE, next good packet processed normally.
  - Stimulus: C000 header.
  - Required: err_pkt, then DRAIN to last.
- rst asserted during DATA with write_valid high.
  - Required: all outputs drop to their reset values asynchronously.
  - Then a fresh single write completes correctly.
